// File: rtl/multi_clock_divider.sv
// Multi-channel programmable divider: per-channel one-cycle tick strobe plus 50%-duty clk_out.
// All outputs registered (one clk of latency); free-running, no backpressure.
module multi_clock_divider #(
   parameter int CHANNELS    = 4,
   parameter int CNT_W       = 28,
   parameter int DEFAULT_DIV = 124999
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic [CHANNELS-1:0]                                en,
   input  logic                                               restart,
   input  logic                                               cfg_we,
   input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
   input  logic [CNT_W-1:0]                                   cfg_div,
   output logic [CHANNELS-1:0]                                tick,
   output logic [CHANNELS-1:0]                                clk_out,
   output logic [CHANNELS-1:0]                                pending
);

   localparam int               CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      localparam logic [CH_W-1:0] IDX = CH_W'(c);

      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] active_div;
      logic [CNT_W-1:0] shadow_div;
      logic             pend_q;
      logic             tick_q;
      logic             clk_out_q;
      logic             cfg_hit;
      logic             at_term;

      // Out-of-range indices never match any IDX, so such writes fall on the floor.
      assign cfg_hit = cfg_we && (cfg_ch == IDX);
      // >= so a divisor shrunk below the running count ends the period at once.
      assign at_term = en[c] && (cnt >= active_div);

      always_ff @(posedge clk) begin
         if (rst) begin
            cnt        <= '0;
            active_div <= DEF_DIV;
            shadow_div <= DEF_DIV;
            pend_q     <= 1'b0;
            tick_q     <= 1'b0;
            clk_out_q  <= 1'b0;
         end else if (restart) begin
            cnt       <= '0;
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
            pend_q    <= 1'b0;
            if (cfg_hit) begin
               active_div <= cfg_div;
            end else if (pend_q) begin
               active_div <= shadow_div;
            end
         end else begin
            if (at_term) begin
               cnt       <= '0;
               tick_q    <= 1'b1;
               clk_out_q <= ~clk_out_q;
            end else begin
               tick_q <= 1'b0;
               if (en[c]) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            // A stopped channel or one at its terminal can take the new divisor
            // without a glitch; otherwise it waits in the shadow until the period ends.
            if (cfg_hit) begin
               if (!en[c] || at_term) begin
                  active_div <= cfg_div;
                  pend_q     <= 1'b0;
               end else begin
                  shadow_div <= cfg_div;
                  pend_q     <= 1'b1;
               end
            end else if (at_term && pend_q) begin
               active_div <= shadow_div;
               pend_q     <= 1'b0;
            end
         end
      end

      assign tick[c]    = tick_q;
      assign clk_out[c] = clk_out_q;
      assign pending[c] = pend_q;
   end

endmodule
